// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU byte stores are queued in a small FIFO
// and serialised 8N1, LSB first, on a registered TX line.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic               tx,
  output logic               full,
  output logic               busy,
  output logic [FIFO_AW:0]   count,
  output logic               overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0]      BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]      BAUD_ONE = BW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         head;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];

  // A write while full is dropped even if a pop frees a slot at the same edge.
  assign push = we & ~fifo_full;

  // NOTE: the storage array carries no reset; the pointers and count alone
  // define which entries are valid, so clearing the data itself buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata[7:0];
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (we && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        tx_q;
  logic        tx_d;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_MAX);

  // State register; tx is registered here so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the next state.
  always_comb begin
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign tx       = tx_q;
  assign full     = fifo_full;
  assign busy     = (state_q != S_IDLE) | ~fifo_empty;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random traffic, checked by a
// cycle-level frame model and an independent UART receiver feeding a scoreboard.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic          tx;
  logic          full;
  logic          busy;
  logic [AW:0]   count;
  logic          overflow;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wdata    (wdata),
    .tx       (tx),
    .full     (full),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: bytes waiting, byte on the wire, frame start edge.
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur = '0;
  bit         m_active = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_start = 0;
  int         edge_n = 0;
  int         epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock edge of the model, using pre-edge state only.
  task automatic model_edge(input logic w, input logic [7:0] b);
    int  n;
    bit  frame_end;
    bit  do_pop;
    n = m_fifo.size();
    edge_n++;
    frame_end = m_active && (edge_n == m_start + FRAME);
    do_pop    = (n != 0) && (!m_active || frame_end);
    if (frame_end && !do_pop) m_active = 1'b0;
    if (do_pop) begin
      m_cur    = m_fifo.pop_front();
      m_active = 1'b1;
      m_start  = edge_n;
    end
    if (w) begin
      if (n < DEPTH) begin
        m_fifo.push_back(b);
        exp_q.push_back(b);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (edge_n - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    check("tx",       {31'b0, tx},       {31'b0, model_tx()});
    check("count",    {28'b0, count},    m_fifo.size());
    check("full",     {31'b0, full},     {31'b0, m_fifo.size() == DEPTH});
    check("busy",     {31'b0, busy},     {31'b0, m_active || m_fifo.size() != 0});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  // Inputs change just after a falling edge; outputs are compared on the next.
  task automatic step(input logic w, input logic [31:0] d);
    we    = w;
    wdata = d;
    @(posedge clk);
    model_edge(w, d[7:0]);
    @(negedge clk);
    we = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom);
  endtask

  // Asynchronous reset between edges; outputs must react before any clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_fifo.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    epoch++;
    #1;
    check("rst_tx",       {31'b0, tx},       32'd1);
    check("rst_count",    {28'b0, count},    32'd0);
    check("rst_full",     {31'b0, full},     32'd0);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_active || m_fifo.size() != 0 || exp_q.size() != 0) && guard < 3000) begin
      step(1'b0, $urandom);
      guard++;
    end
    check("drain_timeout", guard < 3000, 1);
    idle(4);
  endtask

  // Independent receiver: samples each bit at its centre on falling edges.
  initial begin : rx_monitor
    logic [7:0] got;
    logic       start_bit;
    logic       stop_bit;
    int         ep;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        ep = epoch;
        repeat (CPB / 2) @(negedge clk);
        start_bit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        if (ep == epoch) begin
          check("rx_start_bit", {31'b0, start_bit}, 32'd0);
          check("rx_stop_bit",  {31'b0, stop_bit},  32'd1);
          check("rx_expected_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    @(negedge clk);
    do_reset();
    idle(2);

    // 1: single byte, latency and frame shape
    step(1'b1, 32'h0000_0055);
    check("s1_tx_after_write", {31'b0, tx}, 32'd1);
    check("s1_count_one", {28'b0, count}, 32'd1);
    step(1'b0, 32'h0);
    check("s1_start_low", {31'b0, tx}, 32'd0);
    drain();

    // 2: upper store bits ignored
    step(1'b1, 32'hFFFF_FF41);
    drain();

    // 3: back-to-back frames
    step(1'b1, 32'h0000_00A5);
    step(1'b1, 32'h0000_003C);
    drain();

    // 4: burst of ten, last one dropped
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i));
    check("s4_count", {28'b0, count}, 32'd8);
    check("s4_full", {31'b0, full}, 32'd1);
    check("s4_overflow", {31'b0, overflow}, 32'd1);
    drain();

    // 5: write while full at the edge where a frame ends and pops
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'h60 + 32'(i));
    guard = 0;
    while (edge_n + 1 != m_start + FRAME && guard < 200) begin
      step(1'b0, 32'h0);
      guard++;
    end
    check("s5_wait_timeout", guard < 200, 1);
    check("s5_full_before", {31'b0, full}, 32'd1);
    check("s5_ovf_before", {31'b0, overflow}, 32'd0);
    step(1'b1, 32'h0000_00AA);
    check("s5_count", {28'b0, count}, 32'd7);
    check("s5_overflow", {31'b0, overflow}, 32'd1);
    drain();

    // 6: reset in the middle of a frame with bytes queued
    step(1'b1, 32'h0000_00F0);
    step(1'b1, 32'h0000_0011);
    step(1'b1, 32'h0000_0022);
    step(1'b1, 32'h0000_0033);
    guard = 0;
    while (edge_n != m_start + 5 * CPB + CPB / 2 && guard < 200) begin
      step(1'b0, 32'h0);
      guard++;
    end
    check("s6_wait_timeout", guard < 200, 1);
    do_reset();
    idle(FRAME + 20);
    step(1'b1, 32'h0000_005A);
    check("s6_tx_after_write", {31'b0, tx}, 32'd1);
    step(1'b0, 32'h0);
    check("s6_start_low", {31'b0, tx}, 32'd0);
    drain();

    // Random traffic: a dense phase that overruns the FIFO, then a sparse one
    do_reset();
    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 1, $urandom);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 39) == 0, $urandom);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
